// File: rtl/down_counter_timer_pkg.sv
// Shared state encoding and default width for the down counter / countdown timer.
package down_counter_pkg;
    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/down_counter_timer_if.sv
// Control/status bundle of the down counter: Load/LoadVal/En/AutoReload in, Q/Zero/Borrow/Busy out.
interface down_counter_timer_if
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic             En;
    logic             AutoReload;
    logic [WIDTH-1:0] Q;
    logic             Zero;
    logic             Borrow;
    logic             Busy;

    modport master (
        output Load, LoadVal, En, AutoReload,
        input  Q, Zero, Borrow, Busy
    );

    modport slave (
        input  Load, LoadVal, En, AutoReload,
        output Q, Zero, Borrow, Busy
    );
endinterface

// File: rtl/down_counter_timer_core.sv
// WIDTH-bit count register: sync clear > load > decrement, with Q==1 / Q==0 compares.
// One cycle from any command to q_o; no backpressure.
module down_counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] q_o,
    output logic             is_one_o,
    output logic             is_zero_o
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (load_i) begin
            q_d = load_val_i;
        end else if (dec_i) begin
            // Wraps naturally modulo 2^WIDTH, which the free-run mode relies on.
            q_d = q_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        q_q <= q_d;
    end

    assign q_o       = q_q;
    assign is_one_o  = (q_q == WIDTH'(1));
    assign is_zero_o = (q_q == '0);
endmodule

// File: rtl/down_counter_timer.sv
// Loadable down counter, one-shot or periodic, Borrow pulse at terminal count; DOWN_COUNTER_FREERUN_EN adds idle free-run.
// Load->Q 1 cycle, Borrow registered; no backpressure, En gates counting.
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 Reset,
    down_counter_timer_if.slave  bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] reload_q;
    logic             borrow_q, borrow_d;

    logic             run;
    logic             term;
    logic             core_clr;
    logic             core_load;
    logic             core_dec;
    logic [WIDTH-1:0] core_val;
    logic             is_one;
    logic             is_zero;

    assign run  = (state_q == RUN);
    // Terminal count only counts when Load does not pre-empt it.
    assign term = run && bus.En && is_one && !bus.Load;

    always_comb begin
        core_clr  = Reset || (term && !bus.AutoReload);
        core_load = bus.Load || (term && bus.AutoReload);
        core_val  = bus.Load ? bus.LoadVal : reload_q;
        core_dec  = run && bus.En && !is_one;
        borrow_d  = term;
`ifdef DOWN_COUNTER_FREERUN_EN
        if (!run && bus.En) begin
            core_dec = 1'b1;
            borrow_d = is_zero && !bus.Load;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        if (bus.Load) begin
            state_d = (bus.LoadVal != '0) ? RUN : IDLE;
        end else if (term && !bus.AutoReload) begin
            state_d = DONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            reload_q <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            borrow_q <= borrow_d;
            if (bus.Load) begin
                reload_q <= bus.LoadVal;
            end
        end
    end

    down_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk_i      (CLK),
        .clr_i      (core_clr),
        .load_i     (core_load),
        .load_val_i (core_val),
        .dec_i      (core_dec),
        .q_o        (bus.Q),
        .is_one_o   (is_one),
        .is_zero_o  (is_zero)
    );

    assign bus.Zero   = is_zero;
    assign bus.Borrow = borrow_q;
    assign bus.Busy   = run;
endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed vector table, corner sequences, random vs. model.
module tb_down_counter_timer;
    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic CLK;
    logic Reset;

    down_counter_timer_if #(.WIDTH(W)) bus ();

    down_counter_timer #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit       rst;
        bit       load;
        bit [3:0] val;
        bit       en;
        bit       ar;
        bit [3:0] exp_q;
        bit       exp_borrow;
        bit       exp_busy;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: count value, reload value, whether a countdown is active, last borrow.
    int m_q      = 0;
    int m_rel    = 0;
    bit m_active = 0;
    bit m_borrow = 0;

    task automatic model_edge(input bit rst, input bit load, input int val, input bit en, input bit ar);
        if (rst) begin
            m_q = 0; m_rel = 0; m_active = 0; m_borrow = 0;
        end else if (load) begin
            m_q = val; m_rel = val; m_active = (val != 0); m_borrow = 0;
        end else if (m_active) begin
            m_borrow = 0;
            if (en) begin
                if (m_q == 1) begin
                    m_borrow = 1;
                    if (ar) m_q = m_rel;
                    else begin m_q = 0; m_active = 0; end
                end else begin
                    m_q = m_q - 1;
                end
            end
        end else begin
            m_borrow = 0;
`ifdef DOWN_COUNTER_FREERUN_EN
            if (en) begin
                m_borrow = (m_q == 0);
                m_q = (m_q + MOD - 1) % MOD;
            end
`endif
        end
    endtask

    task automatic check(input string name, input int q, input bit b, input bit busy);
        bit [3:0] eq;
        eq = q[3:0];
        n_checks++;
        if (bus.Q !== eq || bus.Zero !== (eq == 4'd0) || bus.Borrow !== b || bus.Busy !== busy) begin
            n_fail++;
            $display("FAIL %s: got Q=%0d Zero=%b Borrow=%b Busy=%b, want Q=%0d Zero=%b Borrow=%b Busy=%b",
                     name, bus.Q, bus.Zero, bus.Borrow, bus.Busy, eq, (eq == 4'd0), b, busy);
        end
    endtask

    task automatic step(input bit rst, input bit load, input int val, input bit en, input bit ar);
        @(negedge CLK);
        Reset          = rst;
        bus.Load       = load;
        bus.LoadVal    = val[3:0];
        bus.En         = en;
        bus.AutoReload = ar;
        @(posedge CLK);
        model_edge(rst, load, val, en, ar);
        #1;
    endtask

    function automatic void add(input bit rst, input bit load, input int val, input bit en, input bit ar,
                                input int q, input bit b, input bit busy);
        vec_t v;
        v.rst = rst; v.load = load; v.val = val[3:0]; v.en = en; v.ar = ar;
        v.exp_q = q[3:0]; v.exp_borrow = b; v.exp_busy = busy;
        vecs.push_back(v);
    endfunction

    initial begin
        Reset = 1'b1; bus.Load = 1'b0; bus.LoadVal = '0; bus.En = 1'b0; bus.AutoReload = 1'b0;

        // rst load val en ar | q borrow busy
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);
`ifndef DOWN_COUNTER_FREERUN_EN
        add(0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0);
`endif
        // one-shot from 5
        add(0, 1, 5, 1, 0, 5, 0, 1);
        add(0, 0, 0, 1, 0, 4, 0, 1);
        add(0, 0, 0, 1, 0, 3, 0, 1);
        add(0, 0, 0, 1, 0, 2, 0, 1);
        add(0, 0, 0, 1, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);
        // periodic from 3, nine enabled cycles
        add(0, 1, 3, 1, 1, 3, 0, 1);
        for (int i = 1; i <= 9; i++)
            add(0, 0, 0, 1, 1, 3 - ((i - 1) % 3 + 1) + ((i % 3 == 0) ? 3 : 0), (i % 3 == 0), 1);
        // En gating
        add(0, 1, 4, 0, 0, 4, 0, 1);
        add(0, 0, 0, 1, 0, 3, 0, 1);
        add(0, 0, 0, 0, 0, 3, 0, 1);
        add(0, 0, 0, 1, 0, 2, 0, 1);
        add(0, 0, 0, 0, 0, 2, 0, 1);
        // Load pre-empts terminal count, then reset mid-count
        add(0, 1, 2, 0, 0, 2, 0, 1);
        add(0, 0, 0, 1, 0, 1, 0, 1);
        add(0, 1, 7, 1, 0, 7, 0, 1);
        add(0, 0, 0, 1, 0, 6, 0, 1);
        add(0, 0, 0, 1, 0, 5, 0, 1);
        add(1, 0, 0, 1, 0, 0, 0, 0);
        // Load of zero stays idle; count of 1 with reload gives back-to-back borrows
        add(0, 1, 0, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 1, 0, 1);
        add(0, 0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 0, 1, 1, 1, 1, 1);
        add(0, 0, 0, 0, 1, 1, 0, 1);
        // reset drops a pending borrow
        add(0, 0, 0, 1, 1, 1, 1, 1);
        add(1, 0, 0, 1, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].load, int'(vecs[i].val), vecs[i].en, vecs[i].ar);
            check($sformatf("vec%0d", i), int'(vecs[i].exp_q), vecs[i].exp_borrow, vecs[i].exp_busy);
        end

`ifdef DOWN_COUNTER_FREERUN_EN
        step(1, 0, 0, 0, 0);
        check("fr_reset", 0, 0, 0);
        step(0, 0, 0, 1, 0);
        check("fr_wrap", 15, 1, 0);
        step(0, 0, 0, 1, 0);
        check("fr_dec", 14, 0, 0);
`endif

        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            bit r, l, e, a;
            int v;
            r = ($urandom_range(0, 39) == 0);
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            a = $urandom_range(0, 1);
            v = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, MOD - 1);
            step(r, l, v, e, a);
            check($sformatf("rand%0d", i), m_q, m_borrow, m_active);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
